// File: rtl/data_mem.sv
// Data memory: word RAM plus MMIO page; reads are combinational (0 cycles), writes commit on posedge, never stalls.
// Optional RDCNT/WRCNT access counters are built only when DATA_MEM_ACCESS_STATS_EN is defined.
module data_mem #(
    parameter int          DEPTH     = 1024,
    parameter int          AW        = 10,
    parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [31:0] ram_adr,
    input  logic [31:0] ram_data,
    output logic [31:0] ram_word,
    input  logic [31:0] io_in,
    output logic [31:0] io_out,
    output logic        misalign
);

    localparam logic [15:0] OFF_IO_OUT = 16'h0000;
    localparam logic [15:0] OFF_IO_IN  = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;
    localparam logic [15:0] OFF_RDCNT  = 16'h0010;
    localparam logic [15:0] OFF_WRCNT  = 16'h0014;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] io_out_q, io_out_d;
    logic        misalign_q, misalign_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] io_meta_q, io_meta_d;
    logic [31:0] io_sync_q, io_sync_d;

    logic          mmio;
    logic          aligned;
    logic [15:0]   offset;
    logic [AW-1:0] ram_idx;
    logic          rd_ok;
    logic          wr_ok;
    logic          bad_access;
    logic          mem_we;
    logic          mmio_wr;
    logic [31:0]   mmio_rdata;

    assign mmio       = (ram_adr[31:16] == MMIO_BASE);
    assign aligned    = (ram_adr[1:0] == 2'b00);
    assign offset     = ram_adr[15:0];
    assign ram_idx    = ram_adr[AW+1:2];
    assign rd_ok      = ram_read & aligned;
    assign wr_ok      = ram_write & aligned;
    assign bad_access = (ram_read | ram_write) & ~aligned;
    assign mmio_wr    = wr_ok & mmio;
    // A write whose edge lands while reset is held must be lost.
    assign mem_we     = wr_ok & ~mmio & ~rst;

`ifdef DATA_MEM_ACCESS_STATS_EN
    logic [31:0] rdcnt_q, rdcnt_d;
    logic [31:0] wrcnt_q, wrcnt_d;
    logic        clr_rdcnt;
    logic        clr_wrcnt;

    assign clr_rdcnt = mmio_wr & (offset == OFF_RDCNT);
    assign clr_wrcnt = mmio_wr & (offset == OFF_WRCNT);

    // A write to either counter is a clear, never counted as a store.
    always_comb begin
        rdcnt_d = rdcnt_q;
        wrcnt_d = wrcnt_q;
        if (clr_rdcnt) begin
            rdcnt_d = '0;
        end else if (rd_ok) begin
            rdcnt_d = rdcnt_q + 32'd1;
        end
        if (clr_wrcnt) begin
            wrcnt_d = '0;
        end else if (wr_ok && !clr_rdcnt) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdcnt_q <= '0;
            wrcnt_q <= '0;
        end else begin
            rdcnt_q <= rdcnt_d;
            wrcnt_q <= wrcnt_d;
        end
    end
`endif

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_IO_OUT: mmio_rdata = io_out_q;
            OFF_IO_IN:  mmio_rdata = io_sync_q;
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_STATUS: mmio_rdata = {31'd0, misalign_q};
`ifdef DATA_MEM_ACCESS_STATS_EN
            OFF_RDCNT:  mmio_rdata = rdcnt_q;
            OFF_WRCNT:  mmio_rdata = wrcnt_q;
`endif
            default:    mmio_rdata = '0;
        endcase
    end

    always_comb begin
        ram_word = '0;
        if (rd_ok) begin
            ram_word = mmio ? mmio_rdata : mem_q[ram_idx];
        end
    end

    always_comb begin
        io_out_d   = io_out_q;
        misalign_d = misalign_q;
        cycle_d    = cycle_q + 32'd1;
        io_meta_d  = io_in;
        io_sync_d  = io_meta_q;
        if (mmio_wr && offset == OFF_IO_OUT) begin
            io_out_d = ram_data;
        end
        if (mmio_wr && offset == OFF_STATUS && ram_data[0]) begin
            misalign_d = 1'b0;
        end
        // Set is evaluated last so it wins over a same-cycle clear.
        if (bad_access) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out_q   <= '0;
            misalign_q <= 1'b0;
            cycle_q    <= '0;
            io_meta_q  <= '0;
            io_sync_q  <= '0;
        end else begin
            io_out_q   <= io_out_d;
            misalign_q <= misalign_d;
            cycle_q    <= cycle_d;
            io_meta_q  <= io_meta_d;
            io_sync_q  <= io_sync_d;
        end
    end

    // RAM array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ram_idx] <= ram_data;
        end
    end

    assign io_out   = io_out_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem.sv
// Randomized scoreboard bench for data_mem against a behavioural memory/MMIO model.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_read = 1'b0;
    logic        ram_write = 1'b0;
    logic [31:0] ram_adr = '0;
    logic [31:0] ram_data = '0;
    logic [31:0] ram_word;
    logic [31:0] io_in = '0;
    logic [31:0] io_out;
    logic        misalign;

    data_mem dut (
        .clk      (clk),
        .rst      (rst),
        .ram_read (ram_read),
        .ram_write(ram_write),
        .ram_adr  (ram_adr),
        .ram_data (ram_data),
        .ram_word (ram_word),
        .io_in    (io_in),
        .io_out   (io_out),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] io_out;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state
    logic [31:0] m_mem [1024];
    logic [31:0] m_io_out;
    logic        m_mis;
    logic [31:0] m_cycle;
    logic [31:0] m_hist[$];
    logic [31:0] io_val = '0;
`ifdef DATA_MEM_ACCESS_STATS_EN
    logic [31:0] m_rd;
    logic [31:0] m_wr;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_io_out = '0;
        m_mis    = 1'b0;
        m_cycle  = '0;
        m_hist   = '{32'd0, 32'd0};
`ifdef DATA_MEM_ACCESS_STATS_EN
        m_rd = '0;
        m_wr = '0;
`endif
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'd0;
        if (a[31:16] != 16'hFFFF) return m_mem[a[11:2]];
        case (a[15:0])
            16'h0000: return m_io_out;
            16'h0004: return m_hist[0];
            16'h0008: return m_cycle;
            16'h000C: return {31'd0, m_mis};
`ifdef DATA_MEM_ACCESS_STATS_EN
            16'h0010: return m_rd;
            16'h0014: return m_wr;
`endif
            default:  return 32'd0;
        endcase
    endfunction

    // Drive one cycle's access, record the expected response, then advance the model by one edge.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic mm;
        logic al;
        ram_read  = rd;
        ram_write = wr;
        ram_adr   = a;
        ram_data  = d;
        io_in     = io_val;
        e.word   = rd ? model_read(a) : 32'd0;
        e.io_out = m_io_out;
        e.mis    = m_mis;
        sb.push_back(e);
        mm = (a[31:16] == 16'hFFFF);
        al = (a[1:0] == 2'b00);
`ifdef DATA_MEM_ACCESS_STATS_EN
        begin
            logic hit_rd;
            logic hit_wr;
            hit_rd = wr && al && mm && a[15:0] == 16'h0010;
            hit_wr = wr && al && mm && a[15:0] == 16'h0014;
            if (hit_rd) m_rd = 0;
            else if (rd && al) m_rd = m_rd + 1;
            if (hit_wr) m_wr = 0;
            else if (wr && al && !hit_rd) m_wr = m_wr + 1;
        end
`endif
        if (wr && al) begin
            if (!mm) m_mem[a[11:2]] = d;
            else if (a[15:0] == 16'h0000) m_io_out = d;
            else if (a[15:0] == 16'h000C && d[0]) m_mis = 1'b0;
        end
        if ((rd || wr) && !al) m_mis = 1'b1;
        m_cycle = m_cycle + 1;
        m_hist.push_back(io_val);
        void'(m_hist.pop_front());
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_ram_adr();
        logic [19:0] up;
        logic [9:0]  idx;
        up  = 20'($urandom);
        idx = 10'($urandom_range(0, 15));
        if (up[19:4] == 16'hFFFF) up[19] = 1'b0;
        return {up, idx, 2'b00};
    endfunction

    function automatic logic [31:0] rand_mmio_adr();
        logic [15:0] offs [8];
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018, 16'h0100};
        return {16'hFFFF, offs[$urandom_range(0, 7)]};
    endfunction

    task automatic random_steps(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 2) == 0) ? rand_mmio_adr() : rand_ram_adr();
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            io_val = $urandom;
            step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, $urandom);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard, well clear of the posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ram_word", ram_word, e.word);
                chk("io_out", io_out, e.io_out);
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checked", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_io_out", io_out, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, {20'h00000, 10'(i), 2'b00}, $urandom);

        step(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0);

        step(1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
        step(1'b1, 1'b0, 32'h0000_0000, 32'h0);

        step(1'b0, 1'b1, 32'h0000_0021, 32'h1111_1111);
        step(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_000C, 32'h1);
        step(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);

        step(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_CAFE);
        io_val = 32'h55;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_0008, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);

        step(1'b0, 1'b1, 32'hFFFF_0010, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0011, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0014, 32'h0);

        random_steps(300);

        step(1'b0, 1'b1, 32'hFFFF_0000, 32'h1234_0001);
        step(1'b1, 1'b0, 32'h0000_0006, 32'h0);
        step(1'b0, 1'b0, 32'h0000_0000, 32'h0);

        // Write in flight when reset rises mid-cycle must be dropped.
        ram_read  = 1'b0;
        ram_write = 1'b1;
        ram_adr   = 32'h0000_0014;
        ram_data  = 32'hBAD0_BAD0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_io_out", io_out, 32'd0);
        chk("async_rst_misalign", {31'd0, misalign}, 32'd0);
        ram_write = 1'b0;
        ram_read  = 1'b1;
        ram_adr   = 32'hFFFF_0008;
        #1;
        chk("async_rst_cycle", ram_word, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        step(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        random_steps(60);

        #5;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
